ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline; consumes id_to_ex_bus from ID, drives MEM and data SRAM.

---
 rtl/ex_stage.sv | 171 +++++++++++++++++
 tb/tb_ex_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage - operand register, 12-op ALU, load/store request, ID forwarding and a
// radix-2 restoring divider for DIV/DIVU. Define EX_DIV_ZERO_FAST_EN to retire zero-divisor divides from IDLE.
module ex_stage #(
   parameter int ID_TO_EX_WD  = 159,
   parameter int EX_TO_MEM_WD = 141,
   parameter int DIV_CYCLES   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5:0]              stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [37:0]             ex_to_id,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   output logic                    stallreq_for_ex
);
   // state | meaning
   // IDLE  | no division in flight; a DIV/DIVU in the input reg latches its operands
   // BUSY  | one restoring shift-subtract per cycle for DIV_CYCLES cycles
   // DONE  | signs applied, hi/lo presented with hilo_we for one cycle
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   logic [ID_TO_EX_WD-1:0] bus_q;
   logic [31:0] pc, inst, rs_v, rt_v;
   logic [11:0] alu_op;
   logic [2:0]  src1_sel;
   logic [3:0]  src2_sel;
   logic        ram_en, rf_we, sel_rf_res;
   logic [3:0]  ram_wen;
   logic [4:0]  rf_waddr;

   // A bubble loads all-zero, which makes every derived output (ALU, SRAM request) zero too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     bus_q <= '0;
      else if (stall[2] && !stall[3]) bus_q <= '0;
      else if (!stall[2])           bus_q <= id_to_ex_bus;
   end

   assign {pc, inst, alu_op, src1_sel, src2_sel, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res,
           rs_v, rt_v} = bus_q;

   logic [31:0] src1_v, src2_v, sra_r, alu_res;
   logic        slt_r, sltu_r;

   assign src1_v = ({32{src1_sel[0]}} & rs_v) | ({32{src1_sel[1]}} & pc)
                 | ({32{src1_sel[2]}} & {27'd0, inst[10:6]});
   assign src2_v = ({32{src2_sel[0]}} & rt_v) | ({32{src2_sel[1]}} & {{16{inst[15]}}, inst[15:0]})
                 | ({32{src2_sel[2]}} & 32'd8) | ({32{src2_sel[3]}} & {16'd0, inst[15:0]});

   assign slt_r  = $signed(src1_v) < $signed(src2_v);
   assign sltu_r = src1_v < src2_v;
   assign sra_r  = $signed(src2_v) >>> src1_v[4:0];

   assign alu_res = ({32{alu_op[11]}} & (src1_v + src2_v))
                  | ({32{alu_op[10]}} & (src1_v - src2_v))
                  | ({32{alu_op[9]}}  & {31'd0, slt_r})
                  | ({32{alu_op[8]}}  & {31'd0, sltu_r})
                  | ({32{alu_op[7]}}  & (src1_v & src2_v))
                  | ({32{alu_op[6]}}  & ~(src1_v | src2_v))
                  | ({32{alu_op[5]}}  & (src1_v | src2_v))
                  | ({32{alu_op[4]}}  & (src1_v ^ src2_v))
                  | ({32{alu_op[3]}}  & (src2_v << src1_v[4:0]))
                  | ({32{alu_op[2]}}  & (src2_v >> src1_v[4:0]))
                  | ({32{alu_op[1]}}  & sra_r)
                  | ({32{alu_op[0]}}  & {src2_v[15:0], 16'd0});

   logic div_valid, div_signed;
   assign div_valid  = (inst[31:26] == 6'd0) && ((inst[5:0] == 6'h1A) || (inst[5:0] == 6'h1B));
   assign div_signed = inst[5:0] == 6'h1A;

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dnd_q, dnd_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic [32:0]      rem_sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         dnd_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         dnd_q   <= dnd_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   assign rem_sh = {rem_q, quo_q[31]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      dnd_d   = dnd_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (div_valid) begin
               rem_d   = '0;
               quo_d   = (div_signed && rs_v[31]) ? (~rs_v + 32'd1) : rs_v;
               dvs_d   = (div_signed && rt_v[31]) ? (~rt_v + 32'd1) : rt_v;
               dnd_d   = rs_v;
               qneg_d  = div_signed && (rs_v[31] ^ rt_v[31]);
               rneg_d  = div_signed && rs_v[31];
               dz_d    = rt_v == 32'd0;
               cnt_d   = '0;
               state_d = BUSY;
`ifdef EX_DIV_ZERO_FAST_EN
               if (rt_v == 32'd0) state_d = DONE;
`endif
            end
         end
         BUSY: begin
            // Quotient bits shift in from the right as dividend bits shift out into the remainder.
            if (rem_sh >= {1'b0, dvs_q}) begin
               rem_d = 32'(rem_sh - {1'b0, dvs_q});
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = rem_sh[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic        hilo_we;
   logic [31:0] hi, lo;
   assign hilo_we = state_q == DONE;
   assign lo = !hilo_we ? 32'd0 : dz_q ? 32'hFFFF_FFFF : qneg_q ? (~quo_q + 32'd1) : quo_q;
   assign hi = !hilo_we ? 32'd0 : dz_q ? dnd_q       : rneg_q ? (~rem_q + 32'd1) : rem_q;

   assign stallreq_for_ex = div_valid && (state_q != DONE);

   assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, alu_res, hilo_we, hi, lo};
   assign ex_to_id      = {rf_we, rf_waddr, alu_res};

   assign data_sram_en    = ram_en;
   assign data_sram_wen   = ram_wen;
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = rt_v;

   logic unused_bits;
   assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table for the ALU/memory path plus hand sequences for the divider,
// stall/bubble handling and asynchronous reset during a division.
module tb_ex_stage;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [5:0]   stall = '0;
   logic [158:0] id_to_ex_bus = '0;
   logic [140:0] ex_to_mem_bus;
   logic [37:0]  ex_to_id;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr, data_sram_wdata;
   logic         stallreq_for_ex;

   int n_chk = 0;
   int n_fail = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
      .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id(ex_to_id),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .stallreq_for_ex(stallreq_for_ex)
   );

   always #5 clk = ~clk;

   localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100,
                           OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR  = 12'h020, OP_XOR  = 12'h010,
                           OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI  = 12'h001;
   localparam logic [2:0] S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
   localparam logic [3:0] S2_RT = 4'b0001, S2_SIMM = 4'b0010, S2_8 = 4'b0100, S2_ZIMM = 4'b1000;

`ifdef EX_DIV_ZERO_FAST_EN
   localparam int DZ_CYC = 1;
`else
   localparam int DZ_CYC = 33;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] op;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic        ren;
      logic [3:0]  wen;
      logic        rfwe;
      logic [4:0]  waddr;
      logic        sel;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [158:0] mk(input vec_t v);
      return {v.pc, v.inst, v.op, v.s1, v.s2, v.ren, v.wen, v.rfwe, v.waddr, v.sel, v.rs, v.rt};
   endfunction

   function automatic logic [158:0] mk_div(input logic [31:0] inst, input logic [31:0] rs,
                                           input logic [31:0] rt);
      return {32'hBFC0_0100, inst, 12'd0, S1_RS, S2_RT, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, rs, rt};
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, " mem_bus"}, 160'(ex_to_mem_bus), 160'd0);
      chk({name, " to_id"}, 160'(ex_to_id), 160'd0);
      chk({name, " sram"}, 160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 160'd0);
      chk({name, " stallreq"}, 160'(stallreq_for_ex), 160'd0);
   endtask

   task automatic load_div(input logic [158:0] b);
      @(negedge clk);
      id_to_ex_bus = b;
      stall = 6'd0;
      @(posedge clk);
      #1;
   endtask

   // Entered #1 after the edge that loaded the divide; holds EX until stallreq drops.
   task automatic div_wait(input string name, input logic [31:0] elo, input logic [31:0] ehi,
                           input int ecyc, input logic [158:0] nxt);
      int n = 0;
      stall = 6'b001111;
      id_to_ex_bus = '0;
      while (stallreq_for_ex && n < 200) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk({name, " stall cycles"}, 160'(n), 160'(ecyc));
      chk({name, " hilo_we"}, 160'(ex_to_mem_bus[64]), 160'd1);
      chk({name, " hi"}, 160'(ex_to_mem_bus[63:32]), 160'(ehi));
      chk({name, " lo"}, 160'(ex_to_mem_bus[31:0]), 160'(elo));
      chk({name, " to_id rf_we"}, 160'(ex_to_id[37]), 160'd0);
      stall = 6'd0;
      id_to_ex_bus = nxt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'hBFC0_0000, 32'h2402_FFFF, OP_ADD,  S1_RS, S2_SIMM, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'd5,         32'h1111_1111, 32'd4};
      vecs[1]  = '{32'hBFC0_0004, 32'h3403_0034, OP_OR,   S1_RS, S2_ZIMM, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'h0000_1200, 32'd0,         32'h0000_1234};
      vecs[2]  = '{32'hBFC0_0008, 32'h3C04_ABCD, OP_LUI,  S1_RS, S2_ZIMM, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'h5555_5555, 32'd0,         32'hABCD_0000};
      vecs[3]  = '{32'hBFC0_000C, 32'h00A4_3023, OP_SUB,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'd3,         32'd5,         32'hFFFF_FFFE};
      vecs[4]  = '{32'hBFC0_0010, 32'h00A4_302A, OP_SLT,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1};
      vecs[5]  = '{32'hBFC0_0014, 32'h00A4_302B, OP_SLTU, S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
      vecs[6]  = '{32'hBFC0_0018, 32'h00A4_3024, OP_AND,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd7,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[7]  = '{32'hBFC0_001C, 32'h00A4_3027, OP_NOR,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd7,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F};
      vecs[8]  = '{32'hBFC0_0020, 32'h00A4_3026, OP_XOR,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd7,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[9]  = '{32'hBFC0_0024, 32'h0000_0100, OP_SLL,  S1_SA, S2_RT,   1'b0, 4'h0, 1'b1, 5'd8,  1'b0, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_00F0};
      vecs[10] = '{32'hBFC0_0028, 32'h0000_0102, OP_SRL,  S1_SA, S2_RT,   1'b0, 4'h0, 1'b1, 5'd8,  1'b0, 32'd0,         32'h8000_0000, 32'h0800_0000};
      vecs[11] = '{32'hBFC0_002C, 32'h0000_0103, OP_SRA,  S1_SA, S2_RT,   1'b0, 4'h0, 1'b1, 5'd8,  1'b0, 32'd0,         32'h8000_0000, 32'hF800_0000};
      vecs[12] = '{32'hBFC0_0030, 32'h0C00_0100, OP_ADD,  S1_PC, S2_8,    1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h1234_5678, 32'd0,         32'hBFC0_0038};
      vecs[13] = '{32'hBFC0_0034, 32'h00A4_3021, OP_ADD,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
      vecs[14] = '{32'hBFC0_0038, 32'h0000_0000, 12'd0,   S1_RS, S2_RT,   1'b0, 4'h0, 1'b0, 5'd0,  1'b0, 32'd5,         32'd6,         32'd0};
      vecs[15] = '{32'hBFC0_003C, 32'h8C85_0004, OP_ADD,  S1_RS, S2_SIMM, 1'b1, 4'h0, 1'b1, 5'd5,  1'b1, 32'h0000_1000, 32'd0,         32'h0000_1004};
      vecs[16] = '{32'hBFC0_0040, 32'hAC05_0008, OP_ADD,  S1_RS, S2_SIMM, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0108};

      // Reset state, before and after clock edges with rst held low.
      #2;
      chk_idle_outputs("reset0");
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset1");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         id_to_ex_bus = mk(vecs[i]);
         stall = 6'd0;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d mem_bus", i), 160'(ex_to_mem_bus),
             160'({vecs[i].pc, vecs[i].ren, vecs[i].wen, vecs[i].sel, vecs[i].rfwe, vecs[i].waddr,
                   vecs[i].exp, 1'b0, 64'd0}));
         chk($sformatf("vec%0d to_id", i), 160'(ex_to_id), 160'({vecs[i].rfwe, vecs[i].waddr, vecs[i].exp}));
         chk($sformatf("vec%0d sram", i), 160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
             160'({vecs[i].ren, vecs[i].wen, vecs[i].exp, vecs[i].rt}));
         chk($sformatf("vec%0d stallreq", i), 160'(stallreq_for_ex), 160'd0);
      end

      // Store is in EX; hold keeps it, then a bubble clears everything.
      @(negedge clk);
      id_to_ex_bus = mk(vecs[1]);
      stall = 6'b001100;
      @(posedge clk);
      #1;
      chk("hold sram", 160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          160'({1'b1, 4'hF, 32'h0000_0108, 32'hDEAD_BEEF}));
      @(negedge clk);
      stall = 6'b000100;
      @(posedge clk);
      #1;
      chk_idle_outputs("bubble");
      @(negedge clk);
      stall = 6'd0;
      id_to_ex_bus = '0;

      load_div(mk_div(32'h0085_001A, 32'hFFFF_FFF9, 32'd2));
      div_wait("div -7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, '0);
      chk("after div hilo_we", 160'(ex_to_mem_bus[64]), 160'd0);
      chk("after div stallreq", 160'(stallreq_for_ex), 160'd0);

      load_div(mk_div(32'h0085_001B, 32'hFFFF_FFFF, 32'h10));
      div_wait("divu ffffffff/16", 32'h0FFF_FFFF, 32'h0000_000F, 33, '0);

      load_div(mk_div(32'h0085_001B, 32'h1234_5678, 32'd0));
      div_wait("divu by zero", 32'hFFFF_FFFF, 32'h1234_5678, DZ_CYC, '0);

      load_div(mk_div(32'h0085_001A, 32'hFFFF_FFFB, 32'd0));
      div_wait("div by zero", 32'hFFFF_FFFF, 32'hFFFF_FFFB, DZ_CYC, '0);

      load_div(mk_div(32'h0085_001A, 32'h8000_0000, 32'hFFFF_FFFF));
      div_wait("div min/-1", 32'h8000_0000, 32'h0000_0000, 33, '0);

      // Back-to-back: second divide enters EX during the first one's DONE cycle.
      load_div(mk_div(32'h0085_001A, 32'd100, 32'hFFFF_FFF9));
      div_wait("b2b first", 32'hFFFF_FFF2, 32'h0000_0002, 33, mk_div(32'h0085_001B, 32'd1000, 32'd7));
      div_wait("b2b second", 32'd142, 32'd6, 33, '0);
      chk("b2b end stallreq", 160'(stallreq_for_ex), 160'd0);

      // Asynchronous reset at BUSY cycle 10.
      load_div(mk_div(32'h0085_001A, 32'hFFFF_FFF9, 32'd2));
      stall = 6'b001111;
      id_to_ex_bus = '0;
      repeat (11) @(posedge clk);
      #1;
      chk("pre-reset stallreq", 160'(stallreq_for_ex), 160'd1);
      rst = 1'b0;
      #1;
      chk_idle_outputs("mid-div reset");
      @(negedge clk);
      rst = 1'b1;
      stall = 6'd0;
      @(posedge clk);
      #1;
      chk("post-reset stallreq", 160'(stallreq_for_ex), 160'd0);
      load_div(mk_div(32'h0085_001A, 32'hFFFF_FFF9, 32'd2));
      div_wait("div after reset", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
